// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift-chain sequencer: command modes and FSM states.
package shift_pkg;

    // Command mode encodings on req_mode
    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_CLEAR  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_NOP    = 2'b11;

    // Sequencer FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/shift_seq_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV system clocks while enabled.
// The chain runs on the system clock; this tick acts as its clock enable.
module tick_gen #(
    parameter int unsigned DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count 0..DIV-1 and wrap while enabled; hold at zero otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a serial shift-register chain: LOAD / CLEAR / ROTATE commands
// over valid/ready, paced by a prescaler tick, with a shadow copy of the chain.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 25000000,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [WIDTH-1:0] req_pattern,
    input  logic [CNT_W-1:0] req_count,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned WCW    = $clog2(WIDTH + 1);
    localparam int unsigned STEP_W = (CNT_W > WCW) ? CNT_W : WCW;

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              ser_q, ser_d;
    logic              sh_q, sh_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              run_en;
    logic              tick;

    assign run_en = (state_q == ST_RUN);

    tick_gen #(.DIV(DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (run_en),
        .tick   (tick)
    );

    // Next-state logic for the command FSM, shadow register and strobe outputs
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        steps_d = steps_q;
        ser_d   = 1'b0;
        sh_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // Shadow follows the chain one cycle after each strobe
        q_d     = sh_q ? {ser_q, q_q[WIDTH-1:1]} : q_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mode_d = req_mode;
                    pat_d  = req_pattern;
                    busy_d = 1'b1;
                    case (req_mode)
                        MODE_LOAD, MODE_CLEAR: steps_d = STEP_W'(WIDTH);
                        MODE_ROTATE:           steps_d = STEP_W'(req_count);
                        default:               steps_d = '0;
                    endcase
                    state_d = (steps_d == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    sh_d = 1'b1;
                    case (mode_q)
                        MODE_LOAD: begin
                            ser_d = pat_q[0];
                            pat_d = pat_q >> 1;
                        end
                        // q_d already includes a shift still pending from the
                        // previous strobe, so back-to-back strobes (DIV=1)
                        // feed back the true last-stage value.
                        MODE_ROTATE: ser_d = q_d[0];
                        default:     ser_d = 1'b0;
                    endcase
                    steps_d = steps_q - 1'b1;
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // First DONE cycle raises done; the second returns to IDLE,
                // so done lands one cycle after the final strobe or accept.
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NOP;
            pat_q   <= '0;
            q_q     <= '0;
            steps_q <= '0;
            ser_q   <= 1'b0;
            sh_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            q_q     <= q_d;
            steps_q <= steps_d;
            ser_q   <= ser_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign ser_out   = ser_q;
    assign shift_en  = sh_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign q         = q_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with DIV=4, WIDTH=4, CNT_W=8.
module tb_shift_seq_ctrl;
    import shift_pkg::*;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          clk_en = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic [1:0]    req_mode = 2'b00;
    logic [W-1:0]  req_pattern = '0;
    logic [CW-1:0] req_count = '0;
    logic          req_ready, ser_out, shift_en, busy, done;
    logic [W-1:0]  q;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] mq;  // model of chain contents

    always #5 if (clk_en) clock = ~clock;

    shift_seq_ctrl #(.WIDTH(W), .DIV(D), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_pattern (req_pattern),
        .req_count   (req_count),
        .ser_out     (ser_out),
        .shift_en    (shift_en),
        .busy        (busy),
        .done        (done),
        .q           (q)
    );

    function automatic int num_steps(input logic [1:0] m, input logic [CW-1:0] c);
        if (m == MODE_LOAD || m == MODE_CLEAR) return W;
        if (m == MODE_ROTATE) return int'(c);
        return 0;
    endfunction

    function automatic logic exp_bit(input logic [1:0] m, input logic [W-1:0] p,
                                     input logic [W-1:0] start, input int k);
        if (m == MODE_LOAD) return p[k];
        if (m == MODE_ROTATE) return start[k % W];
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] final_q(input logic [1:0] m, input logic [W-1:0] p,
                                             input logic [CW-1:0] c, input logic [W-1:0] start);
        logic [2*W-1:0] dbl;
        int r;
        if (m == MODE_LOAD) return p;
        if (m == MODE_CLEAR) return '0;
        if (m == MODE_ROTATE) begin
            r = int'(c) % W;
            dbl = {start, start} >> r;
            return dbl[W-1:0];
        end
        return start;
    endfunction

    // Present a command and return just after its accept edge
    task automatic issue(input logic [1:0] m, input logic [W-1:0] p,
                         input logic [CW-1:0] c, input bit keep);
        int n;
        @(negedge clock);
        req_mode = m; req_pattern = p; req_count = c; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL issue_timeout got req_ready=%b exp 1 within 200 cycles", req_ready);
        end
        @(posedge clock);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Follow one accepted command cycle by cycle against the model
    task automatic monitor(input string nm, input logic [1:0] m, input logic [W-1:0] p,
                           input logic [CW-1:0] c);
        int steps, dcyc;
        logic [W-1:0] start, fq;
        logic exp_se, exp_so, pstb, pbit;
        start = mq;
        fq    = final_q(m, p, c, start);
        steps = num_steps(m, c);
        dcyc  = (steps == 0) ? 1 : steps * D + 1;
        pstb  = 1'b0;
        pbit  = 1'b0;
        for (int cyc = 0; cyc <= dcyc + 1; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock);
                #1;
            end
            if (pstb) mq = {pbit, mq[W-1:1]};
            exp_se = (cyc > 0) && (cyc % D == 0) && (cyc / D <= steps);
            exp_so = exp_se ? exp_bit(m, p, start, cyc / D - 1) : 1'b0;
            checks++;
            if (shift_en !== exp_se) begin
                errors++;
                $display("FAIL %s shift_en cyc=%0d got=%b exp=%b", nm, cyc, shift_en, exp_se);
            end
            checks++;
            if (ser_out !== exp_so) begin
                errors++;
                $display("FAIL %s ser_out cyc=%0d got=%b exp=%b", nm, cyc, ser_out, exp_so);
            end
            checks++;
            if (done !== (cyc == dcyc)) begin
                errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", nm, cyc, done, (cyc == dcyc));
            end
            checks++;
            if (busy !== (cyc < dcyc)) begin
                errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", nm, cyc, busy, (cyc < dcyc));
            end
            checks++;
            if (req_ready !== (cyc > dcyc)) begin
                errors++;
                $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, cyc, req_ready, (cyc > dcyc));
            end
            checks++;
            if (q !== mq) begin
                errors++;
                $display("FAIL %s q cyc=%0d got=%b exp=%b", nm, cyc, q, mq);
            end
            pstb = exp_se;
            pbit = exp_so;
        end
        checks++;
        if (q !== fq) begin
            errors++;
            $display("FAIL %s final_q got=%b exp=%b", nm, q, fq);
        end
        mq = fq;
    endtask

    task automatic test_reset;
        clk_en = 1'b0;
        reset  = 1'b1;
        #1;
        checks++; if (q !== '0)        begin errors++; $display("FAIL reset q got=%b exp=0000", q); end
        checks++; if (shift_en !== 0)  begin errors++; $display("FAIL reset shift_en got=%b exp=0", shift_en); end
        checks++; if (ser_out !== 0)   begin errors++; $display("FAIL reset ser_out got=%b exp=0", ser_out); end
        checks++; if (done !== 0)      begin errors++; $display("FAIL reset done got=%b exp=0", done); end
        checks++; if (busy !== 0)      begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 1) begin errors++; $display("FAIL reset req_ready got=%b exp=1", req_ready); end
        mq = '0;
        clk_en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_load;
        issue(MODE_LOAD, 4'b1011, 8'd0, 1'b0);
        monitor("load_1011", MODE_LOAD, 4'b1011, 8'd0);
    endtask

    task automatic test_rotate;
        issue(MODE_ROTATE, 4'b0000, 8'd5, 1'b0);
        monitor("rotate_5", MODE_ROTATE, 4'b0000, 8'd5);
    endtask

    task automatic test_clear;
        issue(MODE_CLEAR, 4'b1111, 8'd3, 1'b0);
        monitor("clear", MODE_CLEAR, 4'b1111, 8'd3);
    endtask

    task automatic test_zero_steps;
        issue(MODE_LOAD, 4'b0110, 8'd0, 1'b0);
        monitor("load_0110", MODE_LOAD, 4'b0110, 8'd0);
        issue(MODE_ROTATE, 4'b1001, 8'd0, 1'b0);
        monitor("rotate_0", MODE_ROTATE, 4'b1001, 8'd0);
        issue(MODE_NOP, 4'b1001, 8'd7, 1'b0);
        monitor("nop", MODE_NOP, 4'b1001, 8'd7);
    endtask

    task automatic test_back_to_back;
        issue(MODE_LOAD, 4'b1100, 8'd0, 1'b1);
        req_mode = MODE_LOAD; req_pattern = 4'b0011; req_count = 8'd9;
        monitor("b2b_first", MODE_LOAD, 4'b1100, 8'd0);
        issue(MODE_LOAD, 4'b0011, 8'd9, 1'b0);
        monitor("b2b_second", MODE_LOAD, 4'b0011, 8'd9);
    endtask

    task automatic test_random;
        logic [1:0] m;
        logic [W-1:0] p;
        logic [CW-1:0] c;
        for (int i = 0; i < 12; i++) begin
            m = 2'($urandom_range(0, 3));
            p = W'($urandom);
            c = CW'($urandom_range(0, 9));
            issue(m, p, c, 1'b0);
            monitor("random", m, p, c);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] start, exp2;
        start = mq;
        issue(MODE_LOAD, 4'b1111, 8'd0, 1'b0);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc == 4 || cyc == 8) begin
                checks++;
                if (shift_en !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset strobe cyc=%0d got=%b exp=1", cyc, shift_en);
                end
            end
        end
        exp2 = {2'b11, start[W-1:2]};
        checks++;
        if (q !== exp2) begin errors++; $display("FAIL midreset partial_q got=%b exp=%b", q, exp2); end
        #2 reset = 1'b1;
        #1;
        checks++; if (q !== '0)        begin errors++; $display("FAIL midreset q got=%b exp=0000", q); end
        checks++; if (busy !== 0)      begin errors++; $display("FAIL midreset busy got=%b exp=0", busy); end
        checks++; if (shift_en !== 0)  begin errors++; $display("FAIL midreset shift_en got=%b exp=0", shift_en); end
        checks++; if (req_ready !== 1) begin errors++; $display("FAIL midreset req_ready got=%b exp=1", req_ready); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        mq = '0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clock);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset after_release cyc=%0d got done=%b busy=%b exp 0 0", cyc, done, busy);
            end
        end
        issue(MODE_LOAD, 4'b0101, 8'd0, 1'b0);
        monitor("load_after_reset", MODE_LOAD, 4'b0101, 8'd0);
    endtask

    initial begin
        test_reset;
        test_load;
        test_rotate;
        test_clear;
        test_zero_steps;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
